mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates an instruction-fetch requester and a data load/store requester
//   onto one shared memory port. Data wins by default; fetch wins whenever
//   the previous grant went to data, so a data stream cannot starve fetch.
//   Request fields are latched at grant and the port only ever shows the
//   latched copy. Reads complete on port_rvalid, writes on port acceptance;
//   the owner's done pulses one cycle later.
//
// Ports
//   clk, rst                          clock, asynchronous active-high reset
//   if_req / if_addr                  fetch request (held until if_done)
//   d_read / d_write / d_addr /
//   d_wdata / d_wstrb                 data request (held until d_done)
//   port_valid/we/addr/wdata/wstrb    shared port request (wstrb 0 on reads)
//   port_ready, port_rvalid, port_rdata  shared port response
//   if_done / if_rdata                fetch completion pulse and data
//   d_done / d_rdata                  data completion pulse and load data
//   stall                             pipeline stall request (combinational)
//   perf_stall_cnt / perf_grant_cnt   performance counters
//
// Configuration
//   ARB_PERF_CNT_EN  when defined, perf counters are implemented; otherwise
//                    both perf outputs are tied to zero.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  input  logic            d_read,
  input  logic            d_write,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic            port_valid,
  output logic            port_we,
  output logic [AW-1:0]   port_addr,
  output logic [DW-1:0]   port_wdata,
  output logic [DW/8-1:0] port_wstrb,
  input  logic            port_ready,
  input  logic            port_rvalid,
  input  logic [DW-1:0]   port_rdata,
  output logic            if_done,
  output logic [DW-1:0]   if_rdata,
  output logic            d_done,
  output logic [DW-1:0]   d_rdata,
  output logic            stall,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_grant_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t state, state_n;
  // Current owner (0=IF, 1=DATA). It is only rewritten at grant, so it also
  // serves as the previous-grant record used by the fairness rule.
  logic   owner;
  logic   grant, grant_data, done_set, capture;
  logic   if_pend, d_pend;

  // A requester whose done is pulsing this cycle still holds its request;
  // masking it keeps IDLE from re-granting an already completed access.
  assign if_pend    = if_req & ~if_done;
  assign d_pend     = (d_read | d_write) & ~d_done;
  assign stall      = if_pend | d_pend;
  assign port_valid = (state == ISSUE);

  always_comb begin
    state_n    = state;
    grant      = 1'b0;
    grant_data = 1'b0;
    done_set   = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (if_pend && (owner || !d_pend)) begin
          grant = 1'b1;
        end else if (d_pend) begin
          grant      = 1'b1;
          grant_data = 1'b1;
        end
        if (grant) state_n = ISSUE;
      end
      ISSUE: begin
        if (port_ready) begin
          if (port_we) begin
            done_set = 1'b1;
            state_n  = IDLE;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (port_rvalid) begin
          capture  = 1'b1;
          done_set = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      port_we    <= 1'b0;
      port_addr  <= '0;
      port_wdata <= '0;
      port_wstrb <= '0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      state   <= state_n;
      if_done <= done_set & ~owner;
      d_done  <= done_set & owner;
      if (grant) begin
        owner <= grant_data;
        if (grant_data) begin
          // Both d_read and d_write high is treated as a store.
          port_we    <= d_write;
          port_addr  <= d_addr;
          port_wdata <= d_write ? d_wdata : '0;
          port_wstrb <= d_write ? d_wstrb : '0;
        end else begin
          port_we    <= 1'b0;
          port_addr  <= if_addr;
          port_wdata <= '0;
          port_wstrb <= '0;
        end
      end
      if (capture) begin
        if (owner) d_rdata  <= port_rdata;
        else       if_rdata <= port_rdata;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] stall_cnt, grant_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      grant_cnt <= '0;
    end else begin
      if (stall)            stall_cnt <= stall_cnt + 32'd1;
      if (if_done | d_done) grant_cnt <= grant_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt;
  assign perf_grant_cnt = grant_cnt;
`else
  assign perf_stall_cnt = '0;
  assign perf_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run checked against a simple requester/memory reference model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, d_read, d_write;
  logic [31:0]   if_addr, d_addr, d_wdata;
  logic [3:0]    d_wstrb;
  logic          port_valid, port_we, port_ready, port_rvalid;
  logic [31:0]   port_addr, port_wdata, port_rdata;
  logic [3:0]    port_wstrb;
  logic          if_done, d_done, stall;
  logic [31:0]   if_rdata, d_rdata, perf_stall_cnt, perf_grant_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .port_valid(port_valid), .port_we(port_we), .port_addr(port_addr),
    .port_wdata(port_wdata), .port_wstrb(port_wstrb),
    .port_ready(port_ready), .port_rvalid(port_rvalid), .port_rdata(port_rdata),
    .if_done(if_done), .if_rdata(if_rdata), .d_done(d_done), .d_rdata(d_rdata),
    .stall(stall), .perf_stall_cnt(perf_stall_cnt), .perf_grant_cnt(perf_grant_cnt)
  );

  // Memory responder state
  logic [31:0] mem [logic [31:0]];
  bit          rnd_lat = 1'b0;
  int          rd_fixed = 0;
  int          ready_cnt = 0;
  bit          rd_pending = 1'b0;
  int          rd_wait = 0;
  logic [31:0] rd_addr = '0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return dflt(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int unsigned b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  // Memory: drives responses at posedge+1, records handshakes at posedge+2.
  initial begin
    port_ready  = 1'b0;
    port_rvalid = 1'b0;
    port_rdata  = '0;
    forever begin
      @(posedge clk); #1;
      port_rvalid = 1'b0;
      port_rdata  = $urandom;
      if (rd_pending) begin
        if (rd_wait == 0) begin
          port_rvalid = 1'b1;
          port_rdata  = mem_rd(rd_addr);
          rd_pending  = 1'b0;
        end else begin
          rd_wait--;
        end
      end
      port_ready = 1'b0;
      if (port_valid) begin
        if (ready_cnt == 0) port_ready = 1'b1;
        else ready_cnt--;
      end
      #1;
      if (port_valid && port_ready) begin
        if (port_we) begin
          mem[port_addr] = merge(mem_rd(port_addr), port_wdata, port_wstrb);
        end else begin
          rd_pending = 1'b1;
          rd_addr    = port_addr;
          rd_wait    = rnd_lat ? int'($urandom_range(0, 3)) : rd_fixed;
        end
        ready_cnt = rnd_lat ? int'($urandom_range(0, 3)) : 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic reset_dut();
    tick();
    rst = 1'b1;
    if_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    tick();
    tick();
    settle();
    rd_pending = 1'b0; ready_cnt = 0; rnd_lat = 1'b0; rd_fixed = 0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    reset_dut();
    mem[32'h100] = 32'h0000_0013;
    for (int c = 0; c <= 4; c++) begin
      tick();
      if (c == 0) begin if_req = 1'b1; if_addr = 32'h100; end
      if (c == 4) if_req = 1'b0;
      settle();
      checks++;
      if (port_valid !== (c == 1)) begin
        errors++; $display("FAIL fetch_port_valid c%0d: got %b expected %b", c, port_valid, (c == 1));
      end
      checks++;
      if (stall !== (c <= 2)) begin
        errors++; $display("FAIL fetch_stall c%0d: got %b expected %b", c, stall, (c <= 2));
      end
      checks++;
      if ({if_done, d_done} !== {(c == 3), 1'b0}) begin
        errors++; $display("FAIL fetch_done c%0d: got %b expected %b", c, {if_done, d_done}, {(c == 3), 1'b0});
      end
      if (c == 1) begin
        checks++;
        if ({port_we, port_addr, port_wstrb} !== {1'b0, 32'h100, 4'h0}) begin
          errors++; $display("FAIL fetch_port_req: got %h expected %h", {port_we, port_addr, port_wstrb}, {1'b0, 32'h100, 4'h0});
        end
      end
      if (c == 3) begin
        checks++;
        if (if_rdata !== 32'h0000_0013) begin
          errors++; $display("FAIL fetch_rdata: got %h expected %h", if_rdata, 32'h13);
        end
      end
      if (c == 4) begin
`ifdef ARB_PERF_CNT_EN
        checks++;
        if ({perf_stall_cnt, perf_grant_cnt} !== {32'd3, 32'd1}) begin
          errors++; $display("FAIL perf_single_fetch: got %0d/%0d expected 3/1", perf_stall_cnt, perf_grant_cnt);
        end
`else
        checks++;
        if ({perf_stall_cnt, perf_grant_cnt} !== 64'd0) begin
          errors++; $display("FAIL perf_disabled: got %0d/%0d expected 0/0", perf_stall_cnt, perf_grant_cnt);
        end
`endif
      end
    end
  endtask

  task automatic test_reset();
    tick();
    rst = 1'b1;
    settle();
    checks++;
    if ({port_valid, port_we, port_addr, port_wdata, port_wstrb} !== 70'd0) begin
      errors++; $display("FAIL reset_port: got %h expected 0", {port_valid, port_we, port_addr, port_wdata, port_wstrb});
    end
    checks++;
    if ({if_done, d_done} !== 2'b00) begin
      errors++; $display("FAIL reset_done: got %b expected 00", {if_done, d_done});
    end
    checks++;
    if ({if_rdata, d_rdata} !== 64'd0) begin
      errors++; $display("FAIL reset_rdata: got %h expected 0", {if_rdata, d_rdata});
    end
    checks++;
    if ({perf_stall_cnt, perf_grant_cnt} !== 64'd0) begin
      errors++; $display("FAIL reset_perf: got %h expected 0", {perf_stall_cnt, perf_grant_cnt});
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [31:0] acc[$];
    int d_cyc = -1;
    int i_cyc = -1;
    reset_dut();
    mem[32'h2000] = 32'hCAFE_F00D;
    mem[32'h104]  = 32'h0010_0093;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (c == 0) begin
        d_read = 1'b1; d_addr = 32'h2000; if_req = 1'b1; if_addr = 32'h104;
      end
      if (d_cyc >= 0 && d_cyc == c - 1) d_read = 1'b0;
      if (i_cyc >= 0 && i_cyc == c - 1) if_req = 1'b0;
      settle();
      if (port_valid && port_ready) acc.push_back(port_addr);
      if (d_done) begin
        d_cyc = c;
        checks++;
        if (d_rdata !== 32'hCAFE_F00D) begin
          errors++; $display("FAIL simul_d_rdata: got %h expected %h", d_rdata, 32'hCAFEF00D);
        end
      end
      if (if_done) begin
        i_cyc = c;
        checks++;
        if (if_rdata !== 32'h0010_0093) begin
          errors++; $display("FAIL simul_if_rdata: got %h expected %h", if_rdata, 32'h00100093);
        end
      end
    end
    checks++;
    if (acc.size() != 2) begin
      errors++; $display("FAIL simul_grant_count: got %0d expected 2", acc.size());
    end else begin
      checks++;
      if ({acc[0], acc[1]} !== {32'h2000, 32'h104}) begin
        errors++; $display("FAIL simul_order: got %h,%h expected 2000,104", acc[0], acc[1]);
      end
    end
    checks++;
    if (d_cyc != 3 || i_cyc != 6) begin
      errors++; $display("FAIL simul_latency: got d=%0d if=%0d expected d=3 if=6", d_cyc, i_cyc);
    end
  endtask

  task automatic test_store_stall();
    int vcnt = 0;
    int acc_c = -1;
    int done_c = -1;
    reset_dut();
    mem[32'h3000] = 32'h1122_3344;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c == 0) begin
        d_write = 1'b1; d_addr = 32'h3000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
        ready_cnt = 4;
      end else if (done_c < 0) begin
        // Disturb the inputs: the port must keep showing the latched request.
        d_addr = $urandom; d_wdata = $urandom; d_wstrb = 4'($urandom);
      end
      if (done_c >= 0 && done_c == c - 1) d_write = 1'b0;
      settle();
      if (port_valid) begin
        vcnt++;
        checks++;
        if ({port_we, port_addr, port_wdata, port_wstrb} !== {1'b1, 32'h3000, 32'hDEAD_BEEF, 4'b0011}) begin
          errors++; $display("FAIL store_stable c%0d: got %h expected %h", c,
            {port_we, port_addr, port_wdata, port_wstrb}, {1'b1, 32'h3000, 32'hDEAD_BEEF, 4'b0011});
        end
      end
      if (port_valid && port_ready) acc_c = c;
      if (d_done) done_c = c;
    end
    checks++;
    if (vcnt != 5 || acc_c != 5 || done_c != 6) begin
      errors++; $display("FAIL store_timing: got issue=%0d acc=%0d done=%0d expected 5/5/6", vcnt, acc_c, done_c);
    end
    checks++;
    if (mem_rd(32'h3000) !== 32'h1122_BEEF) begin
      errors++; $display("FAIL store_merge: got %h expected %h", mem_rd(32'h3000), 32'h1122BEEF);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq = '0;
    int n = 0;
    reset_dut();
    if_req = 1'b1; if_addr = 32'h500;
    d_read = 1'b1; d_addr = 32'h6000;
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick();
      if (d_done === 1'b1) d_addr = d_addr + 32'd4;
      settle();
      if (port_valid && port_ready) begin
        seq = {seq[2:0], (port_addr >= 32'h6000)};
        n++;
      end
    end
    checks++;
    if (n != 4 || seq !== 4'b1010) begin
      errors++; $display("FAIL alternate_grants: got %0d grants seq %b expected 4 grants seq 1010", n, seq);
    end
    if_req = 1'b0; d_read = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    reset_dut();
    rd_fixed = 5;
    for (int c = 0; c < 13; c++) begin
      tick();
      if (c == 0) begin d_read = 1'b1; d_addr = 32'h7000; end
      if (c == 3) begin rst = 1'b1; d_read = 1'b0; end
      if (c == 4) rst = 1'b0;
      settle();
      if (c == 1) begin
        checks++;
        if ({port_valid, port_ready} !== 2'b11) begin
          errors++; $display("FAIL rstwait_issue: got %b expected 11", {port_valid, port_ready});
        end
      end
      if (c == 3) begin
        checks++;
        if ({port_valid, port_addr, d_done} !== 34'd0) begin
          errors++; $display("FAIL rstwait_async: got %h expected 0", {port_valid, port_addr, d_done});
        end
      end
      if (c >= 4) begin
        checks++;
        if ({port_valid, d_done, if_done} !== 3'b000) begin
          errors++; $display("FAIL rstwait_idle c%0d: got %b expected 000", c, {port_valid, d_done, if_done});
        end
      end
    end
    checks++;
    if (d_rdata !== 32'd0) begin
      errors++; $display("FAIL rstwait_rdata: got %h expected 0", d_rdata);
    end
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [logic [31:0]];
    bit ib = 1'b0, db = 1'b0, i_drop = 1'b0, d_drop = 1'b0, dwr = 1'b0;
    logic [31:0] ia = '0, da = '0, dw = '0, exp_rd;
    logic [3:0] ds = '0;
    logic exp_stall;
    int iage = 0, dage = 0, m_stall = 0, m_grant = 0, op;
    reset_dut();
    rnd_lat = 1'b1;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (i_drop) begin if_req = 1'b0; i_drop = 1'b0; end
      if (d_drop) begin d_read = 1'b0; d_write = 1'b0; d_drop = 1'b0; end
      if (!ib && $urandom_range(0, 1) == 1) begin
        ib = 1'b1; iage = 0;
        ia = 32'h1000 + 32'd4 * $urandom_range(0, 15);
        if_req = 1'b1; if_addr = ia;
      end
      if (!db && $urandom_range(0, 1) == 1) begin
        db = 1'b1; dage = 0;
        op = int'($urandom_range(0, 2));
        da = 32'h8000 + 32'd4 * $urandom_range(0, 7);
        dw = $urandom; ds = 4'($urandom);
        dwr = (op != 0);
        d_read = (op != 1); d_write = (op != 0);
        d_addr = da; d_wdata = dw; d_wstrb = ds;
      end
      settle();
      exp_stall = (if_req & ~if_done) | ((d_read | d_write) & ~d_done);
      if (exp_stall) m_stall++;
      checks++;
      if (stall !== exp_stall) begin
        errors++; $display("FAIL rnd_stall c%0d: got %b expected %b", c, stall, exp_stall);
      end
      if (port_valid && port_ready) begin
        checks++;
        if (port_addr >= 32'h1000 && port_addr < 32'h2000) begin
          if (!ib || {port_we, port_addr, port_wstrb} !== {1'b0, ia, 4'h0}) begin
            errors++; $display("FAIL rnd_fetch_req c%0d: got %h expected %h", c, {port_we, port_addr, port_wstrb}, {1'b0, ia, 4'h0});
          end
        end else begin
          if (!db || {port_we, port_addr, port_wstrb} !== {dwr, da, (dwr ? ds : 4'h0)}
              || (dwr && port_wdata !== dw)) begin
            errors++; $display("FAIL rnd_data_req c%0d: got %h/%h expected %h/%h", c,
              {port_we, port_addr, port_wstrb}, port_wdata, {dwr, da, (dwr ? ds : 4'h0)}, dw);
          end
        end
      end
      if (if_done) begin
        m_grant++;
        checks++;
        if (!ib || if_rdata !== dflt(ia)) begin
          errors++; $display("FAIL rnd_fetch_done c%0d: got %h expected %h (pending %b)", c, if_rdata, dflt(ia), ib);
        end
        ib = 1'b0; i_drop = 1'b1;
      end
      if (d_done) begin
        m_grant++;
        exp_rd = ref_mem.exists(da) ? ref_mem[da] : dflt(da);
        checks++;
        if (!db || (!dwr && d_rdata !== exp_rd)) begin
          errors++; $display("FAIL rnd_data_done c%0d: got %h expected %h (pending %b)", c, d_rdata, exp_rd, db);
        end
        if (db && dwr) ref_mem[da] = merge(exp_rd, dw, ds);
        db = 1'b0; d_drop = 1'b1;
      end
      if (ib) iage++;
      if (db) dage++;
      if (iage > 40 || dage > 40) begin
        checks++; errors++;
        $display("FAIL rnd_timeout c%0d: got ages %0d/%0d expected <= 40", c, iage, dage);
        break;
      end
    end
    tick();
    if_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    settle();
`ifdef ARB_PERF_CNT_EN
    checks++;
    if (perf_stall_cnt !== m_stall || perf_grant_cnt !== m_grant) begin
      errors++; $display("FAIL rnd_perf: got %0d/%0d expected %0d/%0d", perf_stall_cnt, perf_grant_cnt, m_stall, m_grant);
    end
`else
    checks++;
    if ({perf_stall_cnt, perf_grant_cnt} !== 64'd0) begin
      errors++; $display("FAIL rnd_perf_disabled: got %0d/%0d expected 0/0", perf_stall_cnt, perf_grant_cnt);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    test_single_fetch();
    test_simultaneous();
    test_reset();
    test_store_stall();
    test_reset();
    test_back_to_back();
    test_reset_in_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
